// File: rtl/digit_entry_if.sv
// Signal bundle between the button/display side and digit_entry.
// The master side drives the raw buttons; the slave side (digit_entry)
// drives the digit values, the digit enables, and the editing/load status.
interface digit_entry_if;
    logic       btn_select;
    logic       btn_inc;
    logic       btn_start;
    logic [3:0] digit_3;
    logic [3:0] digit_2;
    logic [3:0] digit_1;
    logic [3:0] digit_0;
    logic       enable_3;
    logic       enable_2;
    logic       enable_1;
    logic       enable_0;
    logic       editing;
    logic       load;

    modport master (
        output btn_select, btn_inc, btn_start,
        input  digit_3, digit_2, digit_1, digit_0,
        input  enable_3, enable_2, enable_1, enable_0,
        input  editing, load
    );

    modport slave (
        input  btn_select, btn_inc, btn_start,
        output digit_3, digit_2, digit_1, digit_0,
        output enable_3, enable_2, enable_1, enable_0,
        output editing, load
    );
endinterface

// File: rtl/digit_entry.sv
// digit_entry: user-side MM:SS value entry.
// Each of the three raw buttons is synchronised and debounced into a single
// press event. A small IDLE/EDIT/LOAD state machine uses these events to step
// through the digits, increment the selected digit, and hand the entered
// value to the countdown core with a one-cycle load pulse. While a digit is
// being edited it blinks.
module digit_entry #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BLINK_HALF      = 250000
) (
    input  logic          clk,
    input  logic          rst_n,
    digit_entry_if.slave  bus
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int BW = $clog2(BLINK_HALF);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    // Button bit positions within the packed button vectors.
    localparam int BTN_SELECT = 0;
    localparam int BTN_INC    = 1;
    localparam int BTN_START  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EDIT = 2'd1,
        LOAD = 2'd2
    } state_t;

    logic [2:0]    btn_raw;
    logic [2:0]    sync_1;
    logic [2:0]    sync_2;
    logic [2:0]    level;
    logic [DW-1:0] db_cnt [3];
    logic [2:0]    press;

    logic          start_evt;
    logic          select_evt;
    logic          inc_evt;

    state_t        state;
    logic [1:0]    sel;
    logic [3:0]    digits [4];
    logic [BW-1:0] blink_cnt;
    logic          phase_on;
    logic          editing_q;
    logic          load_q;
    logic [3:0]    digit_limit;
    logic [3:0]    digit_next;
    logic [3:0]    enables;

    assign btn_raw = {bus.btn_start, bus.btn_inc, bus.btn_select};

    // Two-flop synchroniser bringing the asynchronous buttons into clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DEB_LAST) begin
                    level[i]  <= sync_2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // A press is the cycle in which a rising accepted level is taken; the
    // state machine acts on it in the same edge that updates the level.
    always_comb begin
        press = '0;
        for (int i = 0; i < 3; i++) begin
            press[i] = sync_2[i] & ~level[i] & (db_cnt[i] == DEB_LAST);
        end
    end

    // Start wins over select, select wins over inc; losers are dropped.
    always_comb begin
        start_evt  = press[BTN_START];
        select_evt = press[BTN_SELECT] & ~press[BTN_START];
        inc_evt    = press[BTN_INC] & ~press[BTN_START] & ~press[BTN_SELECT];
    end

    // Next value of the selected digit; the seconds-tens digit stops at 5.
    always_comb begin
        digit_limit = (sel == 2'd1) ? 4'd5 : 4'd9;
        digit_next  = (digits[sel] == digit_limit) ? 4'd0 : digits[sel] + 4'd1;
    end

    // Entry state machine, digit storage and blink timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 2'd3;
            blink_cnt <= '0;
            phase_on  <= 1'b1;
            editing_q <= 1'b0;
            load_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                digits[i] <= 4'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    blink_cnt <= '0;
                    phase_on  <= 1'b1;
                    if (start_evt) begin
                        state  <= LOAD;
                        load_q <= 1'b1;
                    end else if (select_evt) begin
                        state     <= EDIT;
                        editing_q <= 1'b1;
                        sel       <= 2'd3;
                    end
                end
                EDIT: begin
                    if (start_evt) begin
                        state     <= LOAD;
                        load_q    <= 1'b1;
                        editing_q <= 1'b0;
                    end else if (select_evt) begin
                        blink_cnt <= '0;
                        phase_on  <= 1'b1;
                        if (sel == 2'd0) begin
                            state     <= IDLE;
                            editing_q <= 1'b0;
                            sel       <= 2'd3;
                        end else begin
                            sel <= sel - 2'd1;
                        end
                    end else if (inc_evt) begin
                        blink_cnt   <= '0;
                        phase_on    <= 1'b1;
                        digits[sel] <= digit_next;
                    end else if (blink_cnt == BLINK_LAST) begin
                        blink_cnt <= '0;
                        phase_on  <= ~phase_on;
                    end else begin
                        blink_cnt <= blink_cnt + BW'(1);
                    end
                end
                LOAD: begin
                    load_q <= 1'b0;
                    state  <= IDLE;
                    sel    <= 2'd3;
                end
                default: begin
                    state     <= IDLE;
                    load_q    <= 1'b0;
                    editing_q <= 1'b0;
                    sel       <= 2'd3;
                end
            endcase
        end
    end

    // Blank only the selected digit during the off half of the blink.
    always_comb begin
        enables = 4'b1111;
        if (editing_q && !phase_on) begin
            enables[sel] = 1'b0;
        end
    end

    assign bus.digit_3  = digits[3];
    assign bus.digit_2  = digits[2];
    assign bus.digit_1  = digits[1];
    assign bus.digit_0  = digits[0];
    assign bus.enable_3 = enables[3];
    assign bus.enable_2 = enables[2];
    assign bus.enable_1 = enables[1];
    assign bus.enable_0 = enables[0];
    assign bus.editing  = editing_q;
    assign bus.load     = load_q;

endmodule
